mux_select_arbiter: RTL

- Two-requester round-robin arbiter that owns the select line of a shared 2:1 mux (data0 side = requester 0, data1 side = requester 1).
- Sequences access to a shared single-cycle datapath resource, e.g. one memory/bus port shared between fetch and data access.
- Grants are held across a req/done handshake and tracked with a hold counter. An optional watchdog forces release on over-long holds.

---
 rtl/mux_select_arbiter_if.sv | 23 ++
 rtl/mux_select_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/mux_select_arbiter_if.sv
// mux_select_arbiter_if: request/done/grant bundle between two requesters and the mux-select arbiter
interface mux_select_arbiter_if #(parameter int CNT_W = 4);
    logic             req0_i;
    logic             req1_i;
    logic             done0_i;
    logic             done1_i;
    logic             gnt0_o;
    logic             gnt1_o;
    logic             select_o;
    logic             busy_o;
    logic [CNT_W-1:0] hold_cnt_o;
    logic             timeout_o;

    modport master (
        output req0_i, req1_i, done0_i, done1_i,
        input  gnt0_o, gnt1_o, select_o, busy_o, hold_cnt_o, timeout_o
    );

    modport slave (
        input  req0_i, req1_i, done0_i, done1_i,
        output gnt0_o, gnt1_o, select_o, busy_o, hold_cnt_o, timeout_o
    );
endinterface

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: two-requester round-robin arbiter owning a 2:1 mux select; ARB_TIMEOUT_EN enables the hold watchdog
module mux_select_arbiter #(
    parameter int CNT_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    mux_select_arbiter_if.slave bus
);
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t           state, state_nxt, arb;
    logic             last, last_nxt;
    logic             select, select_nxt;
    logic             timeout, timeout_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             rel, forced, new_grant;

    // Round-robin pick: on a tie the requester that did not win last time gets it
    always_comb begin
        arb = (bus.req0_i && bus.req1_i) ? (last ? GRANT0 : GRANT1) :
              bus.req0_i ? GRANT0 :
              bus.req1_i ? GRANT1 : IDLE;
    end

    // Release detection and next-state; release and re-arbitration share one edge
    always_comb begin
        forced = 1'b0;
        rel    = 1'b1;
        case (state)
            GRANT0: begin
                forced = TO_EN && hold_cnt == LIMIT && bus.req1_i;
                rel    = bus.done0_i || !bus.req0_i || forced;
            end
            GRANT1: begin
                forced = TO_EN && hold_cnt == LIMIT && bus.req0_i;
                rel    = bus.done1_i || !bus.req1_i || forced;
            end
            default: rel = 1'b1;
        endcase
        state_nxt    = rel ? arb : state;
        new_grant    = rel && arb != IDLE;
        last_nxt     = new_grant ? (arb == GRANT1) : last;
        select_nxt   = new_grant ? (arb == GRANT1) : select;
        hold_cnt_nxt = (state_nxt == IDLE || new_grant) ? '0 :
                       (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + 1'b1;
        timeout_nxt  = forced && new_grant;
    end

    // State and datapath registers; pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last     <= 1'b1;
            select   <= 1'b0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            select   <= select_nxt;
            hold_cnt <= hold_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign bus.gnt0_o     = state == GRANT0;
    assign bus.gnt1_o     = state == GRANT1;
    assign bus.busy_o     = state != IDLE;
    assign bus.select_o   = select;
    assign bus.hold_cnt_o = hold_cnt;
    assign bus.timeout_o  = timeout;
endmodule
